// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Package  : scan_pkg
// Shared state encoding, CRC-32 constants and word-geometry helper for the
// multi-chain scan controller.
// Revision : 1.0
// ============================================================================
package scan_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_LOAD     = 3'd2;
    localparam logic [2:0] S_SHIFT_LO = 3'd3;
    localparam logic [2:0] S_SHIFT_HI = 3'd4;
    localparam logic [2:0] S_PUSH     = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    // Shift slots carried by one FIFO word.
    function automatic int calc_bpw(input int data_w, input int num_chains);
        return data_w / num_chains;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_crc32.sv
`default_nettype none
// ============================================================================
// Module   : scan_crc32
// Running CRC-32 (MSB-first, unreflected, no final XOR), one word per cycle.
// Revision : 1.0
// ============================================================================
module scan_crc32
    import scan_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [31:0] data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic        w_fb;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    always_comb begin
        crc_d = crc_q;
        w_fb  = 1'b0;
        if (init_i) begin
            crc_d = CRC_INIT;
        end else if (en_i) begin
            for (int i = 31; i >= 0; i--) begin
                w_fb  = crc_d[31] ^ data_i[i];
                crc_d = {crc_d[30:0], 1'b0};
                if (w_fb) begin
                    crc_d = crc_d ^ CRC_POLY;
                end
            end
        end
    end

    assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_chain_ctrl
// Parallel multi-chain scan controller: pops shift-in words, drives chains
// through a divided scan clock, pushes captured words. Define SCAN_CRC_EN to
// add crc_out, a CRC-32 over every pushed word.
// Revision : 1.0
// ============================================================================
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter int NUM_CHAINS = 1,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int SCK_DIV    = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LEN_W-1:0]      length,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_CHAINS-1:0] scan_in,
    input  logic [NUM_CHAINS-1:0] scan_out,
    output logic                  scan_enable,
    output logic                  scan_ck_enable,
    output logic                  in_rd_en,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_empty,
    output logic                  out_wr_en,
    output logic [DATA_W-1:0]     out_data,
    input  logic                  out_full
`ifdef SCAN_CRC_EN
    ,
    output logic [31:0]           crc_out
`endif
);

    localparam int                BPW       = calc_bpw(DATA_W, NUM_CHAINS);
    localparam int                SLOT_W    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BPW - 1);
    localparam logic [7:0]        DIV_LAST  = 8'(SCK_DIV - 1);

    logic [2:0]            state_q,   state_d;
    logic [LEN_W-1:0]      len_q,     len_d;
    logic [LEN_W-1:0]      cnt_q,     cnt_d;
    logic [SLOT_W-1:0]     slot_q,    slot_d;
    logic [7:0]            div_q,     div_d;
    logic [DATA_W-1:0]     sin_q,     sin_d;
    logic [DATA_W-1:0]     sout_q,    sout_d;
    logic [NUM_CHAINS-1:0] scan_in_q, scan_in_d;
    logic                  rd_q,      rd_d;
    logic                  wr_q,      wr_d;

    logic                  w_div_last;
    logic [LEN_W-1:0]      w_cnt_inc;
    logic [DATA_W-1:0]     w_sin_nxt;

    assign w_div_last = (div_q == DIV_LAST);
    assign w_cnt_inc  = cnt_q + 1'b1;
    assign w_sin_nxt  = sin_q >> NUM_CHAINS;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            slot_q    <= '0;
            div_q     <= '0;
            sin_q     <= '0;
            sout_q    <= '0;
            scan_in_q <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            div_q     <= div_d;
            sin_q     <= sin_d;
            sout_q    <= sout_d;
            scan_in_q <= scan_in_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
        end
    end

    // Pop/push strobes are registered: the FIFO flag is sampled one cycle
    // before the strobe, so no input reaches an output combinationally.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        slot_d    = slot_q;
        div_d     = div_q;
        sin_d     = sin_q;
        sout_d    = sout_q;
        scan_in_d = scan_in_q;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = length;
                    cnt_d   = '0;
                    slot_d  = '0;
                    state_d = (length == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (rd_q) begin
                    state_d = S_LOAD;
                end else if (!in_empty) begin
                    rd_d = 1'b1;
                end
            end
            S_LOAD: begin
                sin_d     = in_data;
                sout_d    = '0;
                div_d     = '0;
                scan_in_d = in_data[NUM_CHAINS-1:0];
                state_d   = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (w_div_last) begin
                    div_d = '0;
                    sout_d[int'(slot_q)*NUM_CHAINS +: NUM_CHAINS] = scan_out;
                    state_d = S_SHIFT_HI;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_SHIFT_HI: begin
                if (w_div_last) begin
                    div_d = '0;
                    cnt_d = w_cnt_inc;
                    if ((w_cnt_inc == len_q) || (slot_q == SLOT_LAST)) begin
                        state_d = S_PUSH;
                    end else begin
                        slot_d    = slot_q + 1'b1;
                        sin_d     = w_sin_nxt;
                        scan_in_d = w_sin_nxt[NUM_CHAINS-1:0];
                        state_d   = S_SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_PUSH: begin
                if (wr_q) begin
                    if (cnt_q == len_q) begin
                        state_d = S_DONE;
                    end else begin
                        slot_d  = '0;
                        state_d = S_FETCH;
                    end
                end else if (!out_full) begin
                    wr_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
        end
    end

    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        scan_enable    = (state_q != S_IDLE) && (state_q != S_DONE);
        scan_ck_enable = (state_q == S_SHIFT_HI);
    end

    assign scan_in   = scan_in_q;
    assign in_rd_en  = rd_q;
    assign out_wr_en = wr_q;
    assign out_data  = sout_q;

`ifdef SCAN_CRC_EN
    logic [31:0] w_crc_word;

    if (DATA_W >= 32) begin : g_crc_trunc
        assign w_crc_word = sout_q[31:0];
    end else begin : g_crc_ext
        assign w_crc_word = {{(32-DATA_W){1'b0}}, sout_q};
    end

    scan_crc32 u_crc (
        .aclk    (aclk),
        .aresetn (aresetn),
        .init_i  ((state_q == S_IDLE) && start),
        .en_i    (wr_q),
        .data_i  (w_crc_word),
        .crc_o   (crc_out)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_chain_ctrl
// Directed bench: one 1-chain controller and one 4-chain, divide-by-3 one.
// Revision : 1.0
// ============================================================================
module tb_scan_chain_ctrl;

    typedef struct {
        logic [15:0] len;
        logic [31:0] pre;
        logic [31:0] d0;
        logic [31:0] d1;
        int          np;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] ech;
    } vec_t;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int ntests = 0;
    int nfail  = 0;

    // ---------------- environment A: 1 chain, SCK_DIV=1 ----------------
    logic        a_start = 1'b0, a_abort = 1'b0, a_full = 1'b0;
    logic        a_force_empty = 1'b0, a_load = 1'b0;
    logic [15:0] a_len = '0;
    logic        a_busy, a_done, a_se, a_ck, a_rd, a_wr, a_empty;
    logic [0:0]  a_sin, a_sout;
    logic [31:0] a_in_data = '0, a_out_data, a_pre = '0, a_ch = '0;
    logic [31:0] a_mem [16];
    logic [31:0] a_ow  [8];
    int          a_wp = 0, a_rp = 0;
    int          a_pops = 0, a_pushes = 0, a_dones = 0, a_ckp = 0;
    logic        a_ck_q = 1'b0;
`ifdef SCAN_CRC_EN
    logic [31:0] a_crc, b_crc;
`endif

    assign a_empty = a_force_empty || (a_wp == a_rp);
    assign a_sout  = a_ch[31];

    scan_chain_ctrl #(.NUM_CHAINS(1), .DATA_W(32), .LEN_W(16), .SCK_DIV(1)) u_dut_a (
        .aclk(aclk), .aresetn(aresetn), .start(a_start), .abort(a_abort), .length(a_len),
        .busy(a_busy), .done(a_done), .scan_in(a_sin), .scan_out(a_sout),
        .scan_enable(a_se), .scan_ck_enable(a_ck), .in_rd_en(a_rd), .in_data(a_in_data),
        .in_empty(a_empty), .out_wr_en(a_wr), .out_data(a_out_data), .out_full(a_full)
`ifdef SCAN_CRC_EN
        , .crc_out(a_crc)
`endif
    );

    always @(posedge aclk) begin
        a_ck_q <= a_ck;
        if (a_rd) begin
            a_in_data <= a_mem[a_rp];
            a_rp      <= (a_rp + 1) % 16;
            a_pops    <= a_pops + 1;
        end
        if (a_wr) begin
            a_ow[a_pushes % 8] <= a_out_data;
            a_pushes           <= a_pushes + 1;
        end
        if (a_done) a_dones <= a_dones + 1;
        if (a_load) begin
            a_ch <= a_pre;
        end else if (a_ck && !a_ck_q) begin
            a_ch  <= {a_ch[30:0], a_sin};
            a_ckp <= a_ckp + 1;
        end
    end

    // ---------------- environment B: 4 chains, SCK_DIV=3 ----------------
    logic        b_start = 1'b0, b_abort = 1'b0, b_full = 1'b0;
    logic        b_force_empty = 1'b0, b_load = 1'b0;
    logic [15:0] b_len = '0;
    logic        b_busy, b_done, b_se, b_ck, b_rd, b_wr, b_empty;
    logic [3:0]  b_sin, b_sout;
    logic [31:0] b_in_data = '0, b_out_data;
    logic [15:0] b_pre [4];
    logic [15:0] b_ch  [4];
    logic [31:0] b_mem [16];
    logic [31:0] b_ow  [8];
    int          b_wp = 0, b_rp = 0;
    int          b_pops = 0, b_pushes = 0, b_dones = 0, b_ckp = 0, b_run = 0, b_badrun = 0;
    logic        b_ck_q = 1'b0;

    assign b_empty = b_force_empty || (b_wp == b_rp);
    always_comb begin
        b_sout = '0;
        for (int c = 0; c < 4; c++) b_sout[c] = b_ch[c][15];
    end

    scan_chain_ctrl #(.NUM_CHAINS(4), .DATA_W(32), .LEN_W(16), .SCK_DIV(3)) u_dut_b (
        .aclk(aclk), .aresetn(aresetn), .start(b_start), .abort(b_abort), .length(b_len),
        .busy(b_busy), .done(b_done), .scan_in(b_sin), .scan_out(b_sout),
        .scan_enable(b_se), .scan_ck_enable(b_ck), .in_rd_en(b_rd), .in_data(b_in_data),
        .in_empty(b_empty), .out_wr_en(b_wr), .out_data(b_out_data), .out_full(b_full)
`ifdef SCAN_CRC_EN
        , .crc_out(b_crc)
`endif
    );

    always @(posedge aclk) begin
        b_ck_q <= b_ck;
        if (b_rd) begin
            b_in_data <= b_mem[b_rp];
            b_rp      <= (b_rp + 1) % 16;
            b_pops    <= b_pops + 1;
        end
        if (b_wr) begin
            b_ow[b_pushes % 8] <= b_out_data;
            b_pushes           <= b_pushes + 1;
        end
        if (b_done) b_dones <= b_dones + 1;
        if (b_ck) begin
            b_run <= b_run + 1;
        end else if (b_ck_q) begin
            if (b_run != 3) b_badrun <= b_badrun + 1;
            b_run <= 0;
        end
        for (int c = 0; c < 4; c++) begin
            if (b_load) begin
                b_ch[c] <= b_pre[c];
            end else if (b_ck && !b_ck_q) begin
                b_ch[c] <= {b_ch[c][14:0], b_sin[c]};
            end
        end
        if (!b_load && b_ck && !b_ck_q) b_ckp <= b_ckp + 1;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic enq_a(input logic [31:0] d);
        a_mem[a_wp] = d;
        a_wp = (a_wp + 1) % 16;
    endtask

    task automatic enq_b(input logic [31:0] d);
        b_mem[b_wp] = d;
        b_wp = (b_wp + 1) % 16;
    endtask

    task automatic load_a(input logic [31:0] pre);
        a_pre = pre; a_load = 1'b1; tick(); a_load = 1'b0;
    endtask

    task automatic op_a(input vec_t v, input string nm);
        int p0, q0, d0c, n;
        load_a(v.pre);
        enq_a(v.d0);
        if (v.np > 1) enq_a(v.d1);
        p0 = a_pushes; q0 = a_pops; d0c = a_dones;
        a_len = v.len; a_start = 1'b1; tick(); a_start = 1'b0;
        n = 0;
        while (!a_done && n < 5000) begin tick(); n++; end
        chk({nm, "_done"}, 32'(a_done), 32'd1);
        tick();
        chk({nm, "_busy_after"}, 32'(a_busy), 32'd0);
        chk({nm, "_pushes"}, 32'(a_pushes - p0), 32'(v.np));
        chk({nm, "_pops"}, 32'(a_pops - q0), 32'(v.np));
        chk({nm, "_done_pulses"}, 32'(a_dones - d0c), 32'd1);
        chk({nm, "_word0"}, a_ow[p0 % 8], v.e0);
        if (v.np > 1) chk({nm, "_word1"}, a_ow[(p0 + 1) % 8], v.e1);
        chk({nm, "_chain"}, a_ch, v.ech);
    endtask

    task automatic op_b(input logic [15:0] len, input int stall, input int exp_lat, input int np,
                        input logic [31:0] e0, input logic [31:0] e1, input logic [15:0] ech0,
                        input string nm);
        int p0, q0, d0c, k0, r0, n;
        p0 = b_pushes; q0 = b_pops; d0c = b_dones; k0 = b_ckp; r0 = b_badrun;
        b_len = len; b_start = 1'b1; tick(); b_start = 1'b0;
        n = 0;
        b_force_empty = (stall > 0);
        while (!b_rd && n < 50) begin tick(); n++; b_force_empty = (n < stall); end
        b_force_empty = 1'b0;
        chk({nm, "_pop_latency"}, 32'(n), 32'(exp_lat));
        n = 0;
        while (!b_done && n < 2000) begin tick(); n++; end
        chk({nm, "_done"}, 32'(b_done), 32'd1);
        tick(); tick();
        chk({nm, "_busy_after"}, 32'(b_busy), 32'd0);
        chk({nm, "_pushes"}, 32'(b_pushes - p0), 32'(np));
        chk({nm, "_pops"}, 32'(b_pops - q0), 32'(np));
        chk({nm, "_done_pulses"}, 32'(b_dones - d0c), 32'd1);
        chk({nm, "_ck_pulses"}, 32'(b_ckp - k0), 32'(len));
        chk({nm, "_ck_width_errs"}, 32'(b_badrun - r0), 32'd0);
        chk({nm, "_word0"}, b_ow[p0 % 8], e0);
        if (np > 1) chk({nm, "_word1"}, b_ow[(p0 + 1) % 8], e1);
        chk({nm, "_chain0"}, 32'(b_ch[0]), 32'(ech0));
    endtask

    // ---------------- test sequence ----------------
    vec_t tv [4];

    initial begin
        int p0, q0, d0c, k0, n, viol;
        tv[0] = '{16'd32, 32'h0000_FFFF, 32'hA5A5_F00F, 32'h0, 1, 32'hFFFF_0000, 32'h0, 32'hF00F_A5A5};
        tv[1] = '{16'd4,  32'hF000_0000, 32'h0000_0005, 32'h0, 1, 32'h0000_000F, 32'h0, 32'h0000_000A};
        tv[2] = '{16'd1,  32'h8000_0000, 32'h0000_0001, 32'h0, 1, 32'h0000_0001, 32'h0, 32'h0000_0001};
        tv[3] = '{16'd33, 32'hFFFF_FFFF, 32'h0000_0001, 32'h1, 2, 32'hFFFF_FFFF, 32'h1, 32'h0000_0001};

        repeat (3) tick();
        chk("reset_a_ctrl", {25'd0, a_busy, a_done, a_sin, a_se, a_ck, a_rd, a_wr}, 32'd0);
        chk("reset_a_data", a_out_data, 32'd0);
        chk("reset_b_ctrl", {21'd0, b_busy, b_done, b_sin, b_se, b_ck, b_rd, b_wr}, 32'd0);
        chk("reset_b_data", b_out_data, 32'd0);
`ifdef SCAN_CRC_EN
        chk("reset_crc", a_crc, 32'hFFFF_FFFF);
`endif
        aresetn = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) op_a(tv[i], $sformatf("vecA%0d", i));

        // Zero-length operation: straight to DONE with no FIFO or chain activity.
        p0 = a_pushes; q0 = a_pops;
        a_len = 16'd0; a_start = 1'b1; tick(); a_start = 1'b0;
        chk("len0_done_cycle", {27'd0, a_done, a_busy, a_se, a_rd, a_wr}, 32'b11000);
        tick();
        chk("len0_idle", {27'd0, a_done, a_busy, a_se, a_rd, a_wr}, 32'd0);
        chk("len0_no_fifo", 32'(a_pushes - p0 + a_pops - q0), 32'd0);

        // Four chains, 10 shifts across two words.
        b_pre[0] = 16'hFFFF; b_pre[1] = 16'h0000; b_pre[2] = 16'hAAAA; b_pre[3] = 16'hF0F0;
        b_load = 1'b1; tick(); b_load = 1'b0;
        enq_b(32'h0000_0000); enq_b(32'h0000_00FF);
        op_b(16'd10, 0, 1, 2, 32'h1515_9D9D, 32'h0000_009D, 16'hFC03, "vecB10");

        // Two shifts with the input FIFO reporting empty for 5 cycles first.
        for (int c = 0; c < 4; c++) b_pre[c] = 16'h0000;
        b_load = 1'b1; tick(); b_load = 1'b0;
        enq_b(32'h0F0F_0F0F);
        op_b(16'd2, 5, 6, 1, 32'h0, 32'h0, 16'h0002, "vecB2_stall");

        // Output FIFO full for 7 cycles in PUSH.
        load_a(32'h0000_FFFF);
        enq_a(32'h0000_0001);
        a_full = 1'b1; k0 = a_ckp; p0 = a_pushes;
        a_len = 16'd32; a_start = 1'b1; tick(); a_start = 1'b0;
        n = 0;
        while ((((a_ckp - k0) < 32) || a_ck) && n < 500) begin tick(); n++; end
        viol = 0;
        for (int i = 0; i < 7; i++) begin
            if (a_wr) viol++;
            tick();
        end
        a_full = 1'b0;
        chk("full_no_push_while_full", 32'(viol), 32'd0);
        chk("full_no_push_same_cycle", 32'(a_wr), 32'd0);
        tick();
        chk("full_push_after_release", 32'(a_wr), 32'd1);
        n = 0;
        while (!a_done && n < 100) begin tick(); n++; end
        tick();
        chk("full_pushes", 32'(a_pushes - p0), 32'd1);
        chk("full_word", a_ow[p0 % 8], 32'hFFFF_0000);

        // Abort during SHIFT_HI.
        load_a(32'h1234_5678);
        enq_a(32'h0000_0003);
        d0c = a_dones; p0 = a_pushes;
        a_len = 16'd32; a_start = 1'b1; tick(); a_start = 1'b0;
        n = 0;
        while (!a_ck && n < 100) begin tick(); n++; end
        chk("abort_reached_hi", 32'(a_ck), 32'd1);
        a_abort = 1'b1; tick(); a_abort = 1'b0;
        chk("abort_outputs_drop", {28'd0, a_busy, a_se, a_ck, a_done}, 32'd0);
        repeat (40) tick();
        chk("abort_no_done", 32'(a_dones - d0c), 32'd0);
        chk("abort_no_push", 32'(a_pushes - p0), 32'd0);
        op_a(tv[2], "after_abort");

`ifdef SCAN_CRC_EN
        op_a('{16'd32, 32'h0, 32'h0, 32'h0, 1, 32'h0, 32'h0, 32'h0}, "crc_zero");
        chk("crc_zero_word", a_crc, 32'hC704_DD7B);
`endif

        // Asynchronous reset in the middle of an operation.
        load_a(32'hFFFF_FFFF);
        enq_a(32'hFFFF_FFFF);
        a_len = 16'd32; a_start = 1'b1; tick(); a_start = 1'b0;
        repeat (10) tick();
        aresetn = 1'b0;
        #1;
        chk("midreset_ctrl", {25'd0, a_busy, a_done, a_sin, a_se, a_ck, a_rd, a_wr}, 32'd0);
        chk("midreset_data", a_out_data, 32'd0);
`ifdef SCAN_CRC_EN
        chk("midreset_crc", a_crc, 32'hFFFF_FFFF);
`endif
        tick(); tick();
        aresetn = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
